// File: rtl/fm_pattern_pkg.sv
// Shared types for the FM pattern source: run modes, FSM states and the
// power-on content of the pattern table.
package fm_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'd0,
    MODE_PATTERN  = 2'd1,
    MODE_PASSTHRU = 2'd2,
    MODE_COUNTER  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Reset value of pattern table entry i, before sizing to the data width
  function automatic logic [31:0] pat_init_word(input int i);
    return 32'h8000_0000 | 32'(i);
  endfunction

endpackage

// File: rtl/fm_pattern_ch_reg.sv
// One output channel: a data/valid holding register that only changes when
// the controller asks for a load, so a stalled word stays perfectly stable.
module fm_pattern_ch_reg
  import fm_pattern_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  vin,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  vout
);

  logic [DATA_WIDTH-1:0] data_d, data_q;
  logic                  vld_d, vld_q;

  // Take the new word on a load, otherwise hold the current one
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (ld) begin
      data_d = din;
      vld_d  = vin;
    end
  end

  // Channel holding register, cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign dout = data_q;
  assign vout = vld_q;

endmodule

// File: rtl/fm_pattern_source.sv
// Multi-channel test pattern source: bursts of table words or counter words
// with programmable gaps, or a registered passthrough of external data.
module fm_pattern_source
  import fm_pattern_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N_CH       = 4,
  parameter int PAT_DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   mode,
  input  logic                         start,
  input  logic                         oneshot,
  input  logic                         stop,
  input  logic [$clog2(PAT_DEPTH):0]   pat_len,
  input  logic [7:0]                   gap_len,
  input  logic                         pat_we,
  input  logic [$clog2(PAT_DEPTH)-1:0] pat_addr,
  input  logic [DATA_WIDTH-1:0]        pat_wdata,
  input  logic [N_CH*DATA_WIDTH-1:0]   pass_data,
  input  logic [N_CH-1:0]              pass_vld,
  input  logic                         mon_ready,
  output logic [N_CH*DATA_WIDTH-1:0]   mon_data,
  output logic [N_CH-1:0]              mon_vld,
  output logic                         busy
);

  localparam int AW = $clog2(PAT_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = DATA_WIDTH - 8;

  state_e                state_d, state_q;
  mode_e                 mode_d, mode_q;
  logic                  oneshot_d, oneshot_q;
  logic [LW-1:0]         len_d, len_q;
  logic [7:0]            gap_d, gap_q;
  logic [LW-1:0]         idx_d, idx_q;
  logic [7:0]            gap_cnt_d, gap_cnt_q;
  logic [CW-1:0]         count_d, count_q;
  logic [DATA_WIDTH-1:0] tbl_d [PAT_DEPTH];
  logic [DATA_WIDTH-1:0] tbl_q [PAT_DEPTH];

  logic                  ld_en, ld_zero, ld_pass;
  logic [LW-1:0]         ld_idx;
  mode_e                 ld_mode;
  logic [LW-1:0]         eff_len;
  logic                  accept;

  assign eff_len = (pat_len == '0) ? LW'(1) : pat_len;
  assign accept  = mon_vld[0] & mon_ready;
  assign busy    = (state_q != ST_IDLE);

  // Pattern table write port, usable in any state
  always_comb begin
    tbl_d = tbl_q;
    if (pat_we) tbl_d[pat_addr] = pat_wdata;
  end

  // Next-state logic and channel load requests
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    oneshot_d = oneshot_q;
    len_d     = len_q;
    gap_d     = gap_q;
    idx_d     = idx_q;
    gap_cnt_d = gap_cnt_q;
    count_d   = count_q;
    ld_en     = 1'b0;
    ld_zero   = 1'b0;
    ld_pass   = 1'b0;
    ld_idx    = '0;
    ld_mode   = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop && (mode_e'(mode) != MODE_OFF)) begin
          state_d   = ST_BURST;
          mode_d    = mode_e'(mode);
          oneshot_d = oneshot;
          len_d     = eff_len;
          gap_d     = gap_len;
          idx_d     = '0;
          count_d   = '0;
          ld_en     = 1'b1;
          ld_mode   = mode_e'(mode);
          ld_pass   = (mode_e'(mode) == MODE_PASSTHRU);
        end
      end
      ST_BURST: begin
        if (stop) begin
          state_d = ST_IDLE;
          ld_en   = 1'b1;
          ld_zero = 1'b1;
        end else if (mode_q == MODE_PASSTHRU) begin
          ld_en   = 1'b1;
          ld_pass = 1'b1;
        end else if (accept) begin
          if (mode_q == MODE_COUNTER) count_d = count_q + CW'(1);
          if (idx_q == len_q - LW'(1)) begin
            if (oneshot_q) begin
              state_d = ST_IDLE;
              ld_en   = 1'b1;
              ld_zero = 1'b1;
            end else if (gap_q == 8'd0) begin
              len_d = eff_len;
              idx_d = '0;
              ld_en = 1'b1;
            end else begin
              state_d   = ST_GAP;
              gap_cnt_d = gap_q;
              ld_en     = 1'b1;
              ld_zero   = 1'b1;
            end
          end else begin
            idx_d  = idx_q + LW'(1);
            ld_en  = 1'b1;
            ld_idx = idx_q + LW'(1);
          end
        end
      end
      ST_GAP: begin
        if (stop) begin
          state_d = ST_IDLE;
          ld_en   = 1'b1;
          ld_zero = 1'b1;
        end else if (gap_cnt_q <= 8'd1) begin
          state_d = ST_BURST;
          len_d   = eff_len;
          idx_d   = '0;
          ld_en   = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ld_en   = 1'b1;
        ld_zero = 1'b1;
      end
    endcase
  end

  // Control registers and pattern table
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_OFF;
      oneshot_q <= 1'b0;
      len_q     <= LW'(1);
      gap_q     <= '0;
      idx_q     <= '0;
      gap_cnt_q <= '0;
      count_q   <= '0;
      for (int i = 0; i < PAT_DEPTH; i++) tbl_q[i] <= DATA_WIDTH'(pat_init_word(i));
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      oneshot_q <= oneshot_d;
      len_q     <= len_d;
      gap_q     <= gap_d;
      idx_q     <= idx_d;
      gap_cnt_q <= gap_cnt_d;
      count_q   <= count_d;
      tbl_q     <= tbl_d;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [AW-1:0]         rd_addr;
    logic [DATA_WIDTH-1:0] ch_din;
    logic                  ch_vin;

    // Build this channel's next word for the selected source
    always_comb begin
      rd_addr = AW'(ld_idx) + AW'(c);
      ch_din  = '0;
      ch_vin  = 1'b0;
      if (ld_zero) begin
        ch_din = '0;
        ch_vin = 1'b0;
      end else if (ld_pass) begin
        ch_din = pass_data[c*DATA_WIDTH +: DATA_WIDTH];
        ch_vin = pass_vld[c];
      end else if (ld_mode == MODE_COUNTER) begin
        ch_din = {8'(c), count_d};
        ch_vin = 1'b1;
      end else begin
        ch_din = tbl_q[rd_addr];
        ch_vin = 1'b1;
      end
    end

    fm_pattern_ch_reg #(.DATA_WIDTH(DATA_WIDTH)) u_reg (
      .clk  (clk),
      .rst  (rst),
      .ld   (ld_en),
      .din  (ch_din),
      .vin  (ch_vin),
      .dout (mon_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .vout (mon_vld[c])
    );
  end

endmodule

// File: tb/tb_fm_pattern_source.sv
// Directed self-checking bench for fm_pattern_source at default parameters.
module tb_fm_pattern_source;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   mode;
  logic         start, oneshot, stop;
  logic [3:0]   pat_len;
  logic [7:0]   gap_len;
  logic         pat_we;
  logic [2:0]   pat_addr;
  logic [31:0]  pat_wdata;
  logic [127:0] pass_data;
  logic [3:0]   pass_vld;
  logic         mon_ready;
  logic [127:0] mon_data;
  logic [3:0]   mon_vld;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  fm_pattern_source dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .start     (start),
    .oneshot   (oneshot),
    .stop      (stop),
    .pat_len   (pat_len),
    .gap_len   (gap_len),
    .pat_we    (pat_we),
    .pat_addr  (pat_addr),
    .pat_wdata (pat_wdata),
    .pass_data (pass_data),
    .pass_vld  (pass_vld),
    .mon_ready (mon_ready),
    .mon_data  (mon_data),
    .mon_vld   (mon_vld),
    .busy      (busy)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] chd(input int c);
    return mon_data[c*32 +: 32];
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (mon_vld !== 4'b0 || busy !== 1'b0 || mon_data !== 128'b0) begin
      failures++;
      $display("[TB] FAIL reset_state vld=%b busy=%b data=%h expected vld=0 busy=0 data=0", mon_vld, busy, mon_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_pattern_oneshot();
    mode = 2'd1; pat_len = 4'd5; gap_len = 8'd2; oneshot = 1'b1; mon_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (mon_vld !== 4'hF || chd(0) !== (32'h8000_0000 + 32'(k)) ||
          chd(1) !== (32'h8000_0001 + 32'(k)) || chd(3) !== (32'h8000_0003 + 32'(k)) || busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL pattern_word%0d vld=%b ch0=%h ch1=%h ch3=%h busy=%b expected ch0=%h", k,
                 mon_vld, chd(0), chd(1), chd(3), busy, 32'h8000_0000 + 32'(k));
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0 || mon_vld !== 4'b0 || mon_data !== 128'b0) begin
      failures++;
      $display("[TB] FAIL pattern_end busy=%b vld=%b expected busy=0 vld=0", busy, mon_vld);
    end
  endtask

  task automatic test_ready_stall();
    logic [31:0] got [5];
    logic [31:0] held;
    int cnt;
    cnt = 0;
    held = '0;
    mode = 2'd1; pat_len = 4'd5; oneshot = 1'b1; mon_ready = 1'b1;
    pulse_start();
    for (int n = 0; n < 15; n++) begin
      mon_ready = !(n >= 2 && n <= 4);
      if (n == 2) held = chd(0);
      if (n == 3 || n == 4) begin
        checks++;
        if (chd(0) !== held || mon_vld !== 4'hF) begin
          failures++;
          $display("[TB] FAIL stall_hold cycle%0d ch0=%h vld=%b expected ch0=%h vld=f", n, chd(0), mon_vld, held);
        end
      end
      if (mon_ready && mon_vld[0] && cnt < 5) begin
        got[cnt] = chd(0);
        cnt++;
      end else if (mon_ready && mon_vld[0]) begin
        cnt++;
      end
      tick();
    end
    mon_ready = 1'b1;
    checks++;
    if (cnt != 5) begin
      failures++;
      $display("[TB] FAIL stall_count got=%0d expected=5", cnt);
    end
    for (int i = 0; i < 5 && i < cnt; i++) begin
      checks++;
      if (got[i] !== 32'h8000_0000 + 32'(i)) begin
        failures++;
        $display("[TB] FAIL stall_word%0d got=%h expected=%h", i, got[i], 32'h8000_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_counter();
    int k;
    logic expv;
    logic [31:0] expd;
    k = 0;
    mode = 2'd3; oneshot = 1'b0; pat_len = 4'd2; gap_len = 8'd3; mon_ready = 1'b1;
    pulse_start();
    for (int n = 0; n < 10; n++) begin
      expv = ((n % 5) < 2);
      expd = expv ? {8'd2, 24'(k)} : 32'h0;
      checks++;
      if (mon_vld[2] !== expv || chd(2) !== expd) begin
        failures++;
        $display("[TB] FAIL counter_cycle%0d vld=%b ch2=%h expected vld=%b ch2=%h", n, mon_vld[2], chd(2), expv, expd);
      end
      if (expv) k++;
      tick();
    end
    pulse_stop();
    checks++;
    if (busy !== 1'b0 || mon_vld !== 4'b0) begin
      failures++;
      $display("[TB] FAIL counter_stop busy=%b vld=%b expected 0/0", busy, mon_vld);
    end
  endtask

  task automatic test_passthru();
    mode = 2'd2; mon_ready = 1'b0; pass_data = '0; pass_vld = '0;
    pulse_start();
    pass_data[3*32 +: 32] = 32'hDEAD_BEEF;
    pass_vld = 4'b1000;
    checks++;
    if (chd(3) !== 32'h0 || mon_vld !== 4'b0 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pass_early ch3=%h vld=%b busy=%b expected ch3=0 vld=0 busy=1", chd(3), mon_vld, busy);
    end
    tick();
    checks++;
    if (chd(3) !== 32'hDEAD_BEEF || mon_vld !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL pass_data ch3=%h vld=%b expected ch3=deadbeef vld=1000", chd(3), mon_vld);
    end
    pass_data[3*32 +: 32] = 32'h1234_5678;
    pass_vld = 4'b0000;
    tick();
    checks++;
    if (chd(3) !== 32'h1234_5678 || mon_vld !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL pass_update ch3=%h vld=%b expected ch3=12345678 vld=0000", chd(3), mon_vld);
    end
    pulse_stop();
    pass_data = '0;
    checks++;
    if (busy !== 1'b0 || mon_data !== 128'b0) begin
      failures++;
      $display("[TB] FAIL pass_stop busy=%b data=%h expected 0", busy, mon_data);
    end
    mon_ready = 1'b1;
  endtask

  task automatic test_stop_pending();
    mode = 2'd1; pat_len = 4'd5; oneshot = 1'b1; mon_ready = 1'b0;
    pulse_start();
    tick();
    checks++;
    if (mon_vld !== 4'hF || chd(0) !== 32'h8000_0000) begin
      failures++;
      $display("[TB] FAIL stop_pending_word vld=%b ch0=%h expected vld=f ch0=80000000", mon_vld, chd(0));
    end
    pulse_stop();
    checks++;
    if (mon_vld !== 4'b0 || busy !== 1'b0 || mon_data !== 128'b0) begin
      failures++;
      $display("[TB] FAIL stop_drop vld=%b busy=%b expected 0/0", mon_vld, busy);
    end
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    checks++;
    if (mon_vld !== 4'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL start_stop_same vld=%b busy=%b expected 0/0", mon_vld, busy);
    end
    mon_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    mode = 2'd1; pat_len = 4'd5; oneshot = 1'b0; gap_len = 8'd1; mon_ready = 1'b1;
    pulse_start();
    tick();
    rst = 1'b1;
    #2;
    checks++;
    if (mon_vld !== 4'b0 || mon_data !== 128'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_async vld=%b busy=%b data=%h expected all 0", mon_vld, busy, mon_data);
    end
    tick();
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      if (mon_vld !== 4'b0 || busy !== 1'b0) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("[TB] FAIL reset_release active_cycles=%0d expected=0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_ch0 [6];
    exp_ch0 = '{32'h8000_0000, 32'h8000_0001, 32'h8000_0000, 32'h8000_0001, 32'h8000_0002, 32'h8000_0000};
    mode = 2'd1; pat_len = 4'd2; gap_len = 8'd0; oneshot = 1'b0; mon_ready = 1'b1;
    pulse_start();
    pat_len = 4'd3;
    for (int n = 0; n < 6; n++) begin
      checks++;
      if (mon_vld !== 4'hF || chd(0) !== exp_ch0[n]) begin
        failures++;
        $display("[TB] FAIL b2b_cycle%0d vld=%b ch0=%h expected vld=f ch0=%h", n, mon_vld, chd(0), exp_ch0[n]);
      end
      tick();
    end
    pulse_stop();
    checks++;
    if (busy !== 1'b0 || mon_vld !== 4'b0) begin
      failures++;
      $display("[TB] FAIL b2b_stop busy=%b vld=%b expected 0/0", busy, mon_vld);
    end
  endtask

  task automatic test_table_write();
    pat_we = 1'b1; pat_addr = 3'd0; pat_wdata = 32'hCAFE_0000;
    tick();
    pat_we = 1'b0;
    mode = 2'd1; pat_len = 4'd0; oneshot = 1'b1; mon_ready = 1'b0;
    pulse_start();
    checks++;
    if (mon_vld !== 4'hF || chd(0) !== 32'hCAFE_0000 || chd(1) !== 32'h8000_0001) begin
      failures++;
      $display("[TB] FAIL table_write_read vld=%b ch0=%h ch1=%h expected ch0=cafe0000 ch1=80000001", mon_vld, chd(0), chd(1));
    end
    pat_we = 1'b1; pat_wdata = 32'h1111_0000;
    tick();
    pat_we = 1'b0;
    checks++;
    if (chd(0) !== 32'hCAFE_0000 || mon_vld !== 4'hF) begin
      failures++;
      $display("[TB] FAIL table_write_hold ch0=%h vld=%b expected ch0=cafe0000 vld=f", chd(0), mon_vld);
    end
    mon_ready = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || mon_vld !== 4'b0) begin
      failures++;
      $display("[TB] FAIL len0_single busy=%b vld=%b expected 0/0", busy, mon_vld);
    end
    pulse_start();
    checks++;
    if (chd(0) !== 32'h1111_0000 || mon_vld !== 4'hF) begin
      failures++;
      $display("[TB] FAIL table_write_next ch0=%h vld=%b expected ch0=11110000 vld=f", chd(0), mon_vld);
    end
    tick();
  endtask

  // Run every scenario in order, then report
  initial begin
    rst = 1'b1; mode = 2'd0; start = 1'b0; oneshot = 1'b0; stop = 1'b0;
    pat_len = 4'd1; gap_len = 8'd0; pat_we = 1'b0; pat_addr = '0; pat_wdata = '0;
    pass_data = '0; pass_vld = '0; mon_ready = 1'b1;
    test_reset();
    test_pattern_oneshot();
    test_ready_stall();
    test_counter();
    test_passthru();
    test_stop_pending();
    test_back_to_back();
    test_reset_mid();
    test_table_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
